// File: rtl/layer_deserializer_if.sv
// Bus bundle for layer_deserializer: serial element input, parallel frame output
// with a valid/ready handshake, plus status (node index, overrun, argmax).
interface layer_deserializer_if #(
    parameter int LAYER_SIZE = 3,
    parameter int BIT_SIZE   = 1
);
    localparam int NODE_W = $clog2(LAYER_SIZE);

    logic                                 in_start;
    logic [BIT_SIZE-1:0]                  in_data;
    logic [NODE_W-1:0]                    node;
    logic [LAYER_SIZE-1:0][BIT_SIZE-1:0]  out_data;
    logic                                 out_valid;
    logic                                 out_ready;
    logic                                 overrun;
    logic [NODE_W-1:0]                    argmax;

    // Producer/consumer side that drives the serial stream and accepts frames
    modport master (
        output in_start, in_data, out_ready,
        input  node, out_data, out_valid, overrun, argmax
    );

    // Deserializer side
    modport slave (
        input  in_start, in_data, out_ready,
        output node, out_data, out_valid, overrun, argmax
    );
endinterface

// File: rtl/layer_deserializer.sv
// Serial-to-parallel frame collector with HOLD/handshake and sticky overrun.
// Optional macro LAYER_DESER_ARGMAX_EN adds a running signed argmax of the frame.
module layer_deserializer #(
    parameter int LAYER_SIZE = 3,
    parameter int BIT_SIZE   = 1
) (
    input  logic                clk,
    input  logic                rst,
    layer_deserializer_if.slave bus
);
    localparam int NODE_W = $clog2(LAYER_SIZE);
    localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(LAYER_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                               state_q, state_d;
    logic [NODE_W-1:0]                    node_q, node_d;
    logic                                 overrun_q, overrun_d;
    logic [LAYER_SIZE-1:0][BIT_SIZE-1:0]  data_q, data_d;
    logic                                 cap_first;
    logic                                 cap_elem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            node_q    <= '0;
            overrun_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            node_q    <= node_d;
            overrun_q <= overrun_d;
            data_q    <= data_d;
        end
    end

    // cap_first: element 0 of a new frame lands in slot 0; cap_elem: slot node_q
    always_comb begin
        state_d   = state_q;
        node_d    = node_q;
        overrun_d = overrun_q;
        cap_first = 1'b0;
        cap_elem  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_start) begin
                    cap_first = 1'b1;
                    node_d    = NODE_W'(1);
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.in_start) begin
                    cap_first = 1'b1;
                    node_d    = NODE_W'(1);
                    overrun_d = 1'b1;
                end else begin
                    cap_elem = 1'b1;
                    if (node_q == LAST_NODE) begin
                        node_d  = '0;
                        state_d = HOLD;
                    end else begin
                        node_d = node_q + NODE_W'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (bus.in_start) begin
                        cap_first = 1'b1;
                        node_d    = NODE_W'(1);
                        state_d   = COLLECT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.in_start) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                node_d  = '0;
            end
        endcase
    end

    always_comb begin
        data_d = data_q;
        if (cap_first) begin
            data_d[0] = bus.in_data;
        end else if (cap_elem) begin
            data_d[node_q] = bus.in_data;
        end
    end

    assign bus.node      = node_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.overrun   = overrun_q;

`ifdef LAYER_DESER_ARGMAX_EN
    logic [BIT_SIZE-1:0] max_q, max_d;
    logic [NODE_W-1:0]   arg_q, arg_d;

    function automatic logic signed_greater(input logic signed [BIT_SIZE-1:0] a,
                                            input logic signed [BIT_SIZE-1:0] b);
        return a > b;
    endfunction

    // Strict greater-than keeps the lower index on ties
    always_comb begin
        max_d = max_q;
        arg_d = arg_q;
        if (cap_first) begin
            max_d = bus.in_data;
            arg_d = '0;
        end else if (cap_elem && signed_greater(bus.in_data, max_q)) begin
            max_d = bus.in_data;
            arg_d = node_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= '0;
            arg_q <= '0;
        end else begin
            max_q <= max_d;
            arg_q <= arg_d;
        end
    end

    assign bus.argmax = arg_q;
`else
    assign bus.argmax = '0;
`endif

endmodule

// File: tb/tb_layer_deserializer.sv
// Self-checking bench for layer_deserializer (LAYER_SIZE=3, BIT_SIZE=4): directed
// frames with literal expectations, then randomized traffic against a frame-level model.
module tb_layer_deserializer;
    localparam int L = 3;
    localparam int B = 4;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    layer_deserializer_if #(.LAYER_SIZE(L), .BIT_SIZE(B)) bus();

    layer_deserializer #(.LAYER_SIZE(L), .BIT_SIZE(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame-level model: count of elements gathered, a holding flag, the frame slots
    int              m_count = 0;
    bit              m_hold  = 1'b0;
    bit              m_ovr   = 1'b0;
    logic [B-1:0]    m_data [L];
    int              m_arg   = 0;

    function automatic int ref_argmax();
        logic signed [B-1:0] best;
        logic signed [B-1:0] v;
        int idx;
        idx  = 0;
        best = m_data[0];
        for (int i = 1; i < L; i++) begin
            v = m_data[i];
            if (v > best) begin
                best = v;
                idx  = i;
            end
        end
        return idx;
    endfunction

    function automatic logic [L*B-1:0] exp_frame();
        logic [L*B-1:0] f;
        for (int i = 0; i < L; i++) f[i*B +: B] = m_data[i];
        return f;
    endfunction

    function automatic int exp_argmax();
`ifdef LAYER_DESER_ARGMAX_EN
        return m_arg;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < L; i++) m_data[i] = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_count = 0;
                m_hold  = 1'b0;
                m_ovr   = 1'b0;
                for (int i = 0; i < L; i++) m_data[i] = '0;
                m_arg   = 0;
            end else if (m_hold) begin
                if (bus.out_ready) begin
                    m_hold = 1'b0;
                    if (bus.in_start) begin
                        m_data[0] = bus.in_data;
                        m_count   = 1;
                    end
                end else if (bus.in_start) begin
                    m_ovr = 1'b1;
                end
            end else if (bus.in_start) begin
                if (m_count != 0) m_ovr = 1'b1;
                m_data[0] = bus.in_data;
                m_count   = 1;
            end else if (m_count != 0) begin
                m_data[m_count] = bus.in_data;
                m_count++;
                if (m_count == L) begin
                    m_count = 0;
                    m_hold  = 1'b1;
                    m_arg   = ref_argmax();
                end
            end
        end
    end

    // Every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("cmp_node",     64'(bus.node),      64'(m_count));
            check("cmp_valid",    64'(bus.out_valid), 64'(m_hold));
            check("cmp_overrun",  64'(bus.overrun),   64'(m_ovr));
            check("cmp_out_data", 64'(bus.out_data),  64'(exp_frame()));
            if (m_hold) check("cmp_argmax", 64'(bus.argmax), 64'(exp_argmax()));
        end
    end

    task automatic step(input bit r, input bit s, input logic [B-1:0] d, input bit rdy);
        rst           = r;
        bus.in_start  = s;
        bus.in_data   = d;
        bus.out_ready = rdy;
        @(negedge clk);
    endtask

    task automatic check_argmax_lit(input string name, input int exp_on);
`ifdef LAYER_DESER_ARGMAX_EN
        check(name, 64'(bus.argmax), 64'(exp_on));
`else
        check(name, 64'(bus.argmax), 64'd0);
`endif
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_start  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_node",    64'(bus.node),      64'd0);
        check("rst_valid",   64'(bus.out_valid), 64'd0);
        check("rst_data",    64'(bus.out_data),  64'd0);
        check("rst_overrun", 64'(bus.overrun),   64'd0);
        check("rst_argmax",  64'(bus.argmax),    64'd0);

        // Frame 5,2,7 with ready high: valid 3 cycles after in_start, one cycle
        step(0, 1, 4'd5, 1);
        check("f1_valid_early", 64'(bus.out_valid), 64'd0);
        step(0, 0, 4'd2, 1);
        step(0, 0, 4'd7, 1);
        check("f1_valid",  64'(bus.out_valid), 64'd1);
        check("f1_data",   64'(bus.out_data),  64'h725);
        check("f1_model",  64'(exp_frame()),   64'h725);
        check_argmax_lit("f1_argmax", 2);
        step(0, 0, 4'd0, 1);
        check("f1_drop", 64'(bus.out_valid), 64'd0);

        // Same frame held for 4 cycles with ready low
        step(0, 1, 4'd5, 0);
        step(0, 0, 4'd2, 0);
        step(0, 0, 4'd7, 0);
        for (int i = 0; i < 4; i++) begin
            check("f2_hold_valid", 64'(bus.out_valid), 64'd1);
            check("f2_hold_data",  64'(bus.out_data),  64'h725);
            step(0, 0, 4'd0, (i == 3));
        end
        check("f2_drop",    64'(bus.out_valid), 64'd0);
        check("f2_overrun", 64'(bus.overrun),   64'd0);

        // in_start during HOLD without handshake drops the new frame
        step(0, 1, 4'd1, 0);
        step(0, 0, 4'd2, 0);
        step(0, 0, 4'd3, 0);
        step(0, 1, 4'd9, 0);
        check("f3_overrun", 64'(bus.overrun),   64'd1);
        check("f3_data",    64'(bus.out_data),  64'h321);
        check("f3_valid",   64'(bus.out_valid), 64'd1);
        step(0, 0, 4'd0, 1);
        check("f3_idle_valid", 64'(bus.out_valid), 64'd0);
        check("f3_idle_node",  64'(bus.node),      64'd0);

        // Restart on element 1; -8 (4'h8) must lose the signed compare
        step(1, 0, 4'd0, 0);
        check("f4_rst_overrun", 64'(bus.overrun), 64'd0);
        step(0, 1, 4'd4, 0);
        step(0, 1, 4'd6, 0);
        check("f4_overrun", 64'(bus.overrun), 64'd1);
        check("f4_node",    64'(bus.node),    64'd1);
        step(0, 0, 4'd8, 0);
        step(0, 0, 4'd1, 0);
        check("f4_valid", 64'(bus.out_valid), 64'd1);
        check("f4_data",  64'(bus.out_data),  64'h186);
        check_argmax_lit("f4_argmax", 0);
        step(0, 0, 4'd0, 1);

        // Back-to-back frames, start coincident with handshake
        step(1, 0, 4'd0, 0);
        step(0, 1, 4'd1, 1);
        step(0, 0, 4'd2, 1);
        step(0, 0, 4'd3, 1);
        check("f5a_data", 64'(bus.out_data), 64'h321);
        step(0, 1, 4'd4, 1);
        check("f5_gap_node", 64'(bus.node), 64'd1);
        step(0, 0, 4'd5, 1);
        step(0, 0, 4'd6, 1);
        check("f5b_valid",   64'(bus.out_valid), 64'd1);
        check("f5b_data",    64'(bus.out_data),  64'h654);
        check("f5b_overrun", 64'(bus.overrun),   64'd0);
        check_argmax_lit("f5b_argmax", 2);
        step(0, 0, 4'd0, 1);

        // Reset mid-COLLECT, then a tie frame 3,3,1
        step(0, 1, 4'd5, 0);
        step(0, 0, 4'd6, 0);
        step(1, 0, 4'd0, 0);
        check("f6_rst_node",  64'(bus.node),      64'd0);
        check("f6_rst_valid", 64'(bus.out_valid), 64'd0);
        check("f6_rst_data",  64'(bus.out_data),  64'd0);
        step(0, 1, 4'd3, 0);
        step(0, 0, 4'd3, 0);
        step(0, 0, 4'd1, 0);
        check("f6_data",  64'(bus.out_data), 64'h133);
        check("f6_model", 64'(ref_argmax()),  64'd0);
        check_argmax_lit("f6_argmax", 0);
        step(0, 0, 4'd0, 1);

        // Randomized traffic, checked every cycle against the model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 249) == 0),
                 ($urandom_range(0, 4) == 0),
                 B'($urandom),
                 ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
